// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub_bit.sv
// One-bit full subtractor cell: d = a - b - bin, bo = borrow out.
module full_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    // Difference and borrow equations of a 1-bit subtractor.
    always_comb begin
        d  = a ^ b ^ bin;
        bo = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: computes a-b one bit per cycle, LSB first.
// Optional feature macro: SERIAL_SUB_FLAGS_EN adds a registered 'zero' flag output.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_FLAGS_EN
    output logic             zero,
`endif
    output logic             bout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           next_state;
    logic             busy_nxt;
    logic             done_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             last_c;
    logic             accept_c;
    logic             cell_d;
    logic             cell_bo;

    full_sub_bit u_cell (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .bin (brw),
        .d   (cell_d),
        .bo  (cell_bo)
    );

    // Control decodes shared by FSM and datapath.
    always_comb begin
        last_c   = (cnt == CW'(WIDTH - 1));
        accept_c = (state != RUN) && start;
        res_nxt  = {cell_d, res[WIDTH-1:1]};
    end

    // State and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state logic; busy/done follow the state being entered.
    always_comb begin
        next_state = state;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_c) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
        busy_nxt = (next_state == RUN);
        done_nxt = (next_state == DONE);
    end

    // Operand capture, serial shift and final result load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            res  <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            zero <= 1'b0;
`endif
        end else if (accept_c) begin
            a_sh <= a;
            b_sh <= b;
            res  <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= res_nxt;
            brw  <= cell_bo;
            cnt  <= last_c ? '0 : CW'(cnt + CW'(1));
            if (last_c) begin
                diff <= res_nxt;
                bout <= cell_bo;
`ifdef SERIAL_SUB_FLAGS_EN
                zero <= (res_nxt == '0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl (WIDTH=8).
module tb_serial_sub_ctrl;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_FLAGS_EN
    logic         zero;
`endif

    int   total = 0;
    int   bad   = 0;
    int   done_seen = 0;
    int   pushed = 0;
    exp_t sb[$];

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_FLAGS_EN
        .zero  (zero),
`endif
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.diff = x - y;
        e.bout = (x < y);
        e.zero = (e.diff == '0);
        return e;
    endfunction

    task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y);
        sb.push_back(model(x, y));
        pushed++;
    endtask

    // Scoreboard consumer: every done pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            exp_t e;
            done_seen++;
            if (sb.size() == 0) begin
                check("extra_done", 32'(done), 32'(0));
            end else begin
                e = sb.pop_front();
                check("diff", 32'(diff), 32'(e.diff));
                check("bout", 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUB_FLAGS_EN
                check("zero", 32'(zero), 32'(e.zero));
`endif
            end
        end
    end

    // Single operation: checks latency, busy length and single-cycle done.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
        int cyc;
        int bcnt;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        push_exp(x, y);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        cyc = 0; bcnt = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(W));
        check("busy_len", 32'(bcnt), 32'(W));
        @(negedge clk);
        check("done_pulse", 32'(done), 32'(0));
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_diff", 32'(diff), 32'(0));
        check("rst_bout", 32'(bout), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h05, 8'h03);
        run_op(8'h03, 8'h05);
        run_op(8'h00, 8'h01);
        run_op(8'hA5, 8'hA5);

        // Result holds while idle with operands wiggling.
        repeat (3) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom);
        end
        check("hold_diff", 32'(diff), 32'(8'h00));
        check("hold_bout", 32'(bout), 32'(0));

        // Start during RUN is ignored.
        @(negedge clk);
        a = 8'h40; b = 8'h0C; start = 1'b1;
        push_exp(8'h40, 8'h0C);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        check("ign_done_seen", 32'(done), 32'(1));
        repeat (W + 4) @(negedge clk);
        check("ign_no_extra", 32'(sb.size()), 32'(0));

        // Back-to-back: start held through DONE.
        @(negedge clk);
        a = 8'h20; b = 8'h01; start = 1'b1;
        push_exp(8'h20, 8'h01);
        @(negedge clk);
        a = 8'h10; b = 8'h01;
        push_exp(8'h10, 8'h01);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        cyc = 0;
        @(negedge clk); cyc++;
        start = 1'b0;
        while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        check("b2b_gap", 32'(cyc), 32'(9));
        check("b2b_diff", 32'(diff), 32'(8'h0F));
        repeat (2) @(negedge clk);

        // Reset mid-operation: abort, outputs clear asynchronously.
        @(negedge clk);
        a = 8'h33; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        check("mid_rst_diff", 32'(diff), 32'(0));
        check("mid_rst_bout", 32'(bout), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 3) @(negedge clk);
        check("abort_no_done", 32'(done_seen), 32'(pushed));

        run_op(8'h80, 8'h7F);

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'(0));
        check("done_count", 32'(done_seen), 32'(pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
